mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (address or pass-through value), store data and control, then performs load/store transactions on a req/ack data-memory port.
- Produces registered writeback outputs and back-pressures execute with in_ready while a transaction is outstanding.
- Handles byte/half/word sizing, byte enables, store-data replication and load sign/zero extension.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/mem_stage_load_align.sv | 47 ++++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the memory-access stage: access size encodings,
// the stage state type and store-side formatting helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Byte-enable pattern for an access; size 2'b11 falls through to word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 4'b0001 << addr_lo;
            SIZE_H:  return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across all lanes so memory can pick by byte enable.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] data);
        case (size)
            SIZE_B:  return {4{data[7:0]}};
            SIZE_H:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// ============================================================================
// load_align
// ----------------------------------------------------------------------------
// Combinational load-data extraction: selects the byte/half lane addressed
// by addr_lo and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata     in  32  raw word returned by data memory
//   addr_lo   in  2   low address bits of the access
//   size      in  2   access size (byte/half/word; 11 treated as word)
//   is_signed in  1   sign-extend byte/half results
//   value     out 32  extended load result
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_B:  value = {{24{is_signed & w_byte[7]}}, w_byte};
            SIZE_H:  value = {{16{is_signed & w_half[15]}}, w_half};
            default: value = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage
// ----------------------------------------------------------------------------
// Memory-access pipeline stage. Non-memory ops pass alu_result straight to
// writeback at one per cycle; loads/stores hold a req/ack transaction on the
// data-memory port and stall execute (in_ready low) until the ack.
// Optional macro: MEM_ALIGN_CHECK_EN - when defined, misaligned half/word
// accesses are not issued and instead return a misalign writeback pulse
// carrying the faulting address; when undefined, low address bits are
// cleared and the access proceeds.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready                execute handshake
//   alu_result, store_data, mem_*    operation from execute
//   rd, reg_write                    writeback destination/enable
//   dmem_*                           data-memory request/response port
//   wb_*                             registered writeback outputs
//   misalign                         misaligned-access pulse (with wb_valid)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mips_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] store_data,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    mem_size,
    input  logic          mem_signed,
    input  logic [4:0]    rd,
    input  logic          reg_write,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic [3:0]    dmem_be,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [4:0]    wb_rd,
    output logic          wb_reg_write,
    output logic          misalign
);

    mem_state_t  r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [4:0]  r_rd;
    logic        r_reg_write;

    logic        w_is_mem;
    logic [31:0] w_addr;
    logic [31:0] w_load_value;

    assign in_ready  = (r_state == IDLE);
    assign dmem_addr = r_addr[AW-1:0];
    assign w_is_mem  = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misaligned;
    always_comb begin
        case (mem_size)
            SIZE_B:  w_misaligned = 1'b0;
            SIZE_H:  w_misaligned = alu_result[0];
            default: w_misaligned = (alu_result[1:0] != 2'b00);
        endcase
    end
    // Misaligned accesses never reach memory, so no address fix-up is needed.
    assign w_addr = alu_result;
`else
    assign misalign = 1'b0;
    // Misaligned half/word accesses are silently forced onto their natural
    // boundary.
    always_comb begin
        case (mem_size)
            SIZE_B:  w_addr = alu_result;
            SIZE_H:  w_addr = {alu_result[31:1], 1'b0};
            default: w_addr = {alu_result[31:2], 2'b00};
        endcase
    end
`endif

    load_align u_load_align (
        .rdata     (dmem_rdata),
        .addr_lo   (r_addr[1:0]),
        .size      (r_size),
        .is_signed (r_signed),
        .value     (w_load_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_size       <= SIZE_B;
            r_signed     <= 1'b0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign     <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (!w_is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_result;
                            wb_rd        <= rd;
                            wb_reg_write <= reg_write;
                        end
`ifdef MEM_ALIGN_CHECK_EN
                        else if (w_misaligned) begin
                            wb_valid     <= 1'b1;
                            misalign     <= 1'b1;
                            wb_data      <= alu_result;
                            wb_rd        <= rd;
                            wb_reg_write <= 1'b0;
                        end
`endif
                        else begin
                            r_state     <= ACCESS;
                            r_addr      <= w_addr;
                            r_size      <= mem_size;
                            r_signed    <= mem_signed;
                            r_rd        <= rd;
                            // A store (including read+write) never writes back.
                            r_reg_write <= reg_write & ~mem_write;
                            dmem_req    <= 1'b1;
                            dmem_we     <= mem_write;
                            dmem_be     <= byte_enable(mem_size, w_addr[1:0]);
                            dmem_wdata  <= store_lanes(mem_size, store_data);
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        r_state      <= IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= r_rd;
                        wb_reg_write <= r_reg_write;
                        if (!dmem_we) begin
                            wb_data <= w_load_value;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage
// ----------------------------------------------------------------------------
// Scoreboard bench for mem_stage: directed stimulus pushes expected
// writebacks into a queue; a monitor pops and compares on every wb_valid.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [4:0]  rd;
    logic        reg_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign;

    always #5 clk = ~clk;

    mem_stage #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_signed   (mem_signed),
        .rd           (rd),
        .reg_write    (reg_write),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .misalign     (misalign)
    );

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every writeback pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_wb: actual wb_data=0x%08h required=no writeback", wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_data) chk("wb_data", wb_data, e.data);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("misalign", 32'(misalign), 32'(e.mis));
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic cd, input logic [4:0] r,
                        input logic w, input logic m);
        exp_t e;
        e.data = d; e.chk_data = cd; e.rd = r; e.rw = w; e.mis = m;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] sd, input logic rdf,
                         input logic wrf, input logic [1:0] sz, input logic sg,
                         input logic [4:0] r, input logic rw);
        in_valid = 1'b1; alu_result = a; store_data = sd; mem_read = rdf;
        mem_write = wrf; mem_size = sz; mem_signed = sg; rd = r; reg_write = rw;
    endtask

    task automatic pass_op(input logic [31:0] a, input logic [4:0] r, input logic rw);
        drive(a, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, r, rw);
        push(a, 1'b1, r, rw, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pass_in_ready", 32'(in_ready), 32'd1);
        chk("pass_no_req", 32'(dmem_req), 32'd0);
    endtask

    // Memory op: ack is asserted on ACCESS cycle number 'ack_cyc' (1 = zero wait).
    task automatic mem_op(input logic [31:0] a, input logic [31:0] sd, input logic rdf,
                          input logic wrf, input logic [1:0] sz, input logic sg,
                          input logic [4:0] r, input logic rw, input int ack_cyc,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_wb);
        drive(a, sd, rdf, wrf, sz, sg, r, rw);
        push(exp_wb, ~wrf, r, rw & ~wrf, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("req", 32'(dmem_req), 32'd1);
        chk("we", 32'(dmem_we), 32'(wrf));
        chk("addr", dmem_addr, exp_addr);
        chk("be", 32'(dmem_be), 32'(exp_be));
        if (wrf) chk("wdata", dmem_wdata, exp_wdata);
        for (int i = 1; i < ack_cyc; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk("addr_hold", dmem_addr, exp_addr);
        end
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("req_hold", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_req", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_signed = 1'b0;
        rd = '0; reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass-through, then two back-to-back.
        pass_op(32'h1234_5678, 5'd7, 1'b1);
        pass_op(32'hA5A5_0001, 5'd1, 1'b1);
        pass_op(32'h0000_0002, 5'd2, 1'b0);

        // Signed byte load, ack on 3rd ACCESS cycle.
        mem_op(32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 5'd3, 1'b1, 3,
               32'h80AA_BBCC, 32'h103, 4'b1000, 32'h0, 32'hFFFF_FF80);
        // Half store, zero wait.
        mem_op(32'h202, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd9, 1'b1, 1,
               32'h0, 32'h202, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        // Unsigned half load at 0.
        mem_op(32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd4, 1'b1, 2,
               32'h1234_F00D, 32'h0, 4'b0011, 32'h0, 32'h0000_F00D);
        // Signed upper half load.
        mem_op(32'h2, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd5, 1'b1, 1,
               32'h8001_0000, 32'h2, 4'b1100, 32'h0, 32'hFFFF_8001);
        // Size 11 behaves as word.
        mem_op(32'h40, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 5'd6, 1'b1, 1,
               32'hCAFE_BABE, 32'h40, 4'b1111, 32'h0, 32'hCAFE_BABE);
        // Unsigned byte load lane 1.
        mem_op(32'h1, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd8, 1'b1, 1,
               32'h0000_80FF, 32'h1, 4'b0010, 32'h0, 32'h0000_0080);
        // Byte store lane 1.
        mem_op(32'h301, 32'h0000_00A5, 1'b0, 1'b1, 2'b00, 1'b0, 5'd10, 1'b1, 2,
               32'h0, 32'h301, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        // Read and write both set: store, no writeback enable.
        mem_op(32'h44, 32'h1122_3344, 1'b1, 1'b1, 2'b10, 1'b0, 5'd11, 1'b1, 1,
               32'h0, 32'h44, 4'b1111, 32'h1122_3344, 32'h0);

        // Misaligned word at 0x101.
`ifdef MEM_ALIGN_CHECK_EN
        drive(32'h101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd12, 1'b1);
        push(32'h101, 1'b1, 5'd12, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mis_no_req", 32'(dmem_req), 32'd0);
        chk("mis_in_ready", 32'(in_ready), 32'd1);
`else
        mem_op(32'h101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd12, 1'b1, 1,
               32'h5566_7788, 32'h100, 4'b1111, 32'h0, 32'h5566_7788);
`endif

        // Ack while idle is ignored (monitor flags any writeback).
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;

        // Reset mid-ACCESS: request drops and a late ack is never consumed.
        drive(32'h500, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd13, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_mid_req_up", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_req_drop", 32'(dmem_req), 32'd0);
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);

        // Stage still works after the mid-transaction reset.
        pass_op(32'h0BAD_F00D, 5'd14, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
